// File: rtl/fb_clear_pkg.sv
// fb_clear_pkg: shared types and constants for the framebuffer clear engine.
// Provides the FSM state enum, default base/size constants and burst sizing.
package fb_clear_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } fb_clear_state_t;

    localparam int unsigned AVM_BURST_W      = 8;
    localparam logic [28:0] FB_DEFAULT_BASE  = 29'h0600_0000;
    localparam int unsigned FB_DEFAULT_WORDS = 153600;

    // Unsigned minimum of the words left and the maximum burst length.
    // burst_len is at most 128, so the result always fits the burst field.
    function automatic logic [AVM_BURST_W-1:0] min_burst(
        input logic [31:0] remaining,
        input int unsigned burst_len
    );
        logic [31:0] blen;
        blen = burst_len;
        if (remaining < blen) begin
            return remaining[AVM_BURST_W-1:0];
        end
        return blen[AVM_BURST_W-1:0];
    endfunction

endpackage

// File: rtl/fb_clear_engine_if.sv
// fb_clear_engine_if: Avalon-MM burst write bus (f2h_sdram1 write port).
// master: address/burstcount/write/writedata/byteenable out, waitrequest in.
interface fb_clear_engine_if
    import fb_clear_pkg::*;
#(
    parameter int unsigned ADDR_W = 29,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0]      avm_address;
    logic [AVM_BURST_W-1:0] avm_burstcount;
    logic                   avm_write;
    logic [DATA_W-1:0]      avm_writedata;
    logic [7:0]             avm_byteenable;
    logic                   avm_waitrequest;

    modport master (
        output avm_address,
        output avm_burstcount,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_burstcount,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest
    );
endinterface

// File: rtl/fb_clear_engine.sv
// fb_clear_engine: Avalon-MM burst write master filling the framebuffer with
// the background colour. Ports: clk, reset (sync, active-high), start,
// back_colour, busy, done, avm (master modport). With FB_CLEAR_PERF_EN
// defined, clear_cycles reports the cycle count of the last clear.
module fb_clear_engine
    import fb_clear_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 29,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       BURST_LEN = 16,
    parameter logic [ADDR_W-1:0] FB_BASE   = ADDR_W'(FB_DEFAULT_BASE),
    parameter int unsigned       FB_WORDS  = FB_DEFAULT_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] back_colour,
    output logic        busy,
    output logic        done,
`ifdef FB_CLEAR_PERF_EN
    output logic [31:0] clear_cycles,
`endif
    fb_clear_engine_if.master avm
);

    fb_clear_state_t        state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [31:0]            rem_q, rem_d;
    logic [31:0]            colour_q, colour_d;
    logic [AVM_BURST_W-1:0] beat_q, beat_d;
    logic [AVM_BURST_W-1:0] burst;
    logic                   accept;
    logic                   last_beat;

    // rem_q only changes at a burst boundary, so burst stays constant
    // for every beat of a burst.
    assign burst     = min_burst(rem_q, BURST_LEN);
    assign accept    = (state_q == BURST) && !avm.avm_waitrequest;
    assign last_beat = accept && (beat_q == burst - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            colour_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            colour_q <= colour_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        colour_d = colour_q;
        beat_d   = beat_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    colour_d = back_colour;
                    addr_d   = FB_BASE;
                    rem_d    = FB_WORDS;
                    beat_d   = '0;
                    state_d  = (FB_WORDS == 0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    beat_d = '0;
                    addr_d = addr_q + ADDR_W'(burst);
                    rem_d  = rem_q - 32'(burst);
                    // Otherwise stay in BURST: next burst begins with no gap.
                    if (rem_q == 32'(burst)) begin
                        state_d = DONE;
                    end
                end else if (accept) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus fields are forced to zero outside a burst.
    always_comb begin
        avm.avm_write      = (state_q == BURST);
        avm.avm_address    = '0;
        avm.avm_burstcount = '0;
        avm.avm_writedata  = '0;
        avm.avm_byteenable = '0;
        if (state_q == BURST) begin
            avm.avm_address    = addr_q;
            avm.avm_burstcount = burst;
            avm.avm_writedata  = {(DATA_W / 32){colour_q}};
            avm.avm_byteenable = 8'hFF;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

`ifdef FB_CLEAR_PERF_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                cyc_q <= '0;
            end
        end else if (cyc_q != 32'hFFFF_FFFF) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign clear_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_fb_clear_engine.sv
// tb_fb_clear_engine: randomized scoreboard bench for fb_clear_engine.
// A reference model queues expected beats; a monitor pops on each accepted beat.
module tb_fb_clear_engine;

    localparam logic [28:0] BASE  = 29'h0600_0000;
    localparam int          WORDS = 40;
    localparam int          BL    = 16;

    typedef struct packed {
        logic [28:0] a;
        logic [7:0]  bc;
        logic [63:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic [31:0] colour = 32'h0;
    logic        busy, done, busy0, done0;
    logic        stall_en = 1'b0;
`ifdef FB_CLEAR_PERF_EN
    logic [31:0] clear_cycles, clear_cycles0;
`endif

    fb_clear_engine_if #(.ADDR_W(29), .DATA_W(64)) bus ();
    fb_clear_engine_if #(.ADDR_W(29), .DATA_W(64)) bus0 ();

    fb_clear_engine #(
        .BURST_LEN (BL),
        .FB_BASE   (BASE),
        .FB_WORDS  (WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .back_colour (colour),
        .busy        (busy),
        .done        (done),
`ifdef FB_CLEAR_PERF_EN
        .clear_cycles(clear_cycles),
`endif
        .avm         (bus.master)
    );

    fb_clear_engine #(
        .BURST_LEN (BL),
        .FB_BASE   (BASE),
        .FB_WORDS  (0)
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .start       (start0),
        .back_colour (colour),
        .busy        (busy0),
        .done        (done0),
`ifdef FB_CLEAR_PERF_EN
        .clear_cycles(clear_cycles0),
`endif
        .avm         (bus0.master)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    cyc = 0;
    int    beats = 0;
    int    dones = 0;
    int    last_beat_cyc = 0;
    int    done_cyc = 0;
    int    wr0_cnt = 0;
    int    done0_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: split the clear into bursts of at most BL words.
    task automatic push_clear(input logic [31:0] c);
        int off;
        int rem;
        int b;
        off = 0;
        rem = WORDS;
        while (rem > 0) begin
            b = (rem < BL) ? rem : BL;
            for (int k = 0; k < b; k++) begin
                exp_q.push_back('{a: BASE + 29'(off), bc: 8'(b), d: {c, c}});
            end
            off += b;
            rem -= b;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.avm_waitrequest  = 1'b0;
        bus0.avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: scoreboard pops, stall stability, pulse counting.
    logic        prev_stall = 1'b0;
    logic [28:0] p_a;
    logic [7:0]  p_bc;
    logic [63:0] p_d;

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_write", bus.avm_write, 1'b1);
                chk("stall_addr", bus.avm_address, p_a);
                chk("stall_bc", bus.avm_burstcount, p_bc);
                chk("stall_data", bus.avm_writedata, p_d);
            end
            if (bus.avm_write) begin
                chk("busy_on_write", busy, 1'b1);
                if (!bus.avm_waitrequest) begin
                    beats++;
                    last_beat_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got beat at %h expected none",
                                 bus.avm_address);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_addr", bus.avm_address, e.a);
                        chk("sb_bc", bus.avm_burstcount, e.bc);
                        chk("sb_data", bus.avm_writedata, e.d);
                        chk("sb_be", bus.avm_byteenable, 8'hFF);
                    end
                end
                prev_stall = bus.avm_waitrequest;
                p_a  = bus.avm_address;
                p_bc = bus.avm_burstcount;
                p_d  = bus.avm_writedata;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (bus0.avm_write) wr0_cnt++;
            if (done0) done0_cnt++;
        end
    end

    task automatic pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == lim) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within %0d", lim);
        end
        @(negedge clk);
    endtask

    task automatic check_clear(input string nm, input int b0, input int d0);
        chk({nm, "_beats"}, 64'(beats - b0), 64'(WORDS));
        chk({nm, "_dones"}, 64'(dones - d0), 64'd1);
        chk({nm, "_sb_left"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_done_lat"}, 64'(done_cyc), 64'(last_beat_cyc + 1));
    endtask

    initial begin
        int b0, d0, w0;
        int k;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_write", bus.avm_write, 1'b0);
        chk("rst_addr", bus.avm_address, 29'h0);
        chk("rst_bc", bus.avm_burstcount, 8'h0);
        chk("rst_be", bus.avm_byteenable, 8'h0);
        chk("rst_data", bus.avm_writedata, 64'h0);
        chk("rst_busy0", busy0, 1'b0);
`ifdef FB_CLEAR_PERF_EN
        chk("rst_perf", clear_cycles, 32'h0);
`endif

        // Clean clear, no stalls.
        colour = 32'h00FF8040;
        push_clear(colour);
        b0 = beats;
        d0 = dones;
        pulse();
        @(negedge clk);
        chk("first_write", bus.avm_write, 1'b1);
        chk("first_data", bus.avm_writedata, 64'h00FF804000FF8040);
        wait_done(200);
        check_clear("plain", b0, d0);
`ifdef FB_CLEAR_PERF_EN
        chk("perf_41", clear_cycles, 32'd41);
        repeat (5) @(negedge clk);
        chk("perf_hold", clear_cycles, 32'd41);
`endif

        // Random stalls.
        stall_en = 1'b1;
        colour = $urandom();
        push_clear(colour);
        b0 = beats;
        d0 = dones;
        pulse();
`ifdef FB_CLEAR_PERF_EN
        @(negedge clk);
        chk("perf_clear", clear_cycles, 32'd0);
`endif
        wait_done(2000);
        check_clear("stall", b0, d0);
        stall_en = 1'b0;

        // Extra start pulses and a colour change mid-clear.
        colour = $urandom();
        push_clear(colour);
        b0 = beats;
        d0 = dones;
        pulse();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        colour = 32'h12345678;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(200);
        check_clear("restart", b0, d0);
        repeat (30) @(negedge clk);
        chk("no_queue_beats", 64'(beats - b0), 64'(WORDS));
        chk("no_queue_dones", 64'(dones - d0), 64'd1);
        chk("idle_busy", busy, 1'b0);

        // Reset during beat 5 of burst 2.
        colour = $urandom();
        push_clear(colour);
        b0 = beats;
        pulse();
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (beats - b0 >= 20) break;
        end
        chk("pre_reset_beats", 64'(beats - b0), 64'd20);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_write", bus.avm_write, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        exp_q.delete();
        colour = $urandom();
        push_clear(colour);
        b0 = beats;
        d0 = dones;
        pulse();
        @(negedge clk);
        chk("post_rst_addr", bus.avm_address, BASE);
        wait_done(200);
        check_clear("post_rst", b0, d0);

        // Zero-size clear.
        w0 = wr0_cnt;
        @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        chk("zero_done", done0, 1'b1);
        chk("zero_busy", busy0, 1'b1);
        @(negedge clk);
        chk("zero_done_end", done0, 1'b0);
        chk("zero_busy_end", busy0, 1'b0);
        chk("zero_writes", 64'(wr0_cnt - w0), 64'd0);
        chk("zero_done_cnt", 64'(done0_cnt), 64'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog");
    end

endmodule
